edge_window_counter: RTL and testbench
======================================

EDGE_WINDOW_COUNTER -- requirements
Module: edge_window_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, giving the bit width of the edge count.
REQ-002 SHALL provide parameter WINDOW, default 16, giving the measurement window length in clock cycles (legal range 2..65535).
REQ-003 SHALL have exactly one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in0  input  1  monitored single-bit gate output (e.g. a NOR_GATE out), sampled every clk edge.
REQ-007 start  input  1  request to begin a measurement window.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 out_valid  output  1  result available.
REQ-010 out_count  output  WIDTH  number of rising edges seen on in0 in the window.
REQ-011 overflow  output  1  sticky flag: count saturated during the current/last window.
REQ-012 busy  output  1  high in COUNT state.

Function
REQ-013 SHALL register in0 into prev every cycle in all states; rising edge = (in0==1 && prev==0) at a clk edge.
REQ-014 SHALL implement states IDLE, COUNT, HOLD; encoding is implementer's choice.
REQ-015 IDLE: out_valid=0, busy=0; start==1 at a clk edge -> COUNT, out_count cleared to 0, overflow cleared to 0, window timer cleared to 0.
REQ-016 COUNT: busy=1; each clk edge, a detected rising edge increments out_count by 1; timer increments by 1.
REQ-017 Edge detection in the first COUNT cycle SHALL compare against prev sampled in the preceding IDLE cycle.
REQ-018 SHALL stay in COUNT for exactly WINDOW clk edges; on the edge where timer==WINDOW-1 -> HOLD, and an edge detected on that same clk edge SHALL be counted.
REQ-019 Latency: start sampled at edge t -> out_valid high after edge t+WINDOW.
REQ-020 Saturation: an increment at out_count==2^WIDTH-1 SHALL leave out_count unchanged and set overflow=1.
REQ-021 overflow SHALL remain set until the next IDLE->COUNT or HOLD->COUNT transition, or reset.
REQ-022 HOLD: out_valid=1, out_count and overflow stable; in0 edges ignored (prev still updates).
REQ-023 HOLD with out_ready==1 at a clk edge: transfer completes; start==0 -> IDLE; start==1 on the same edge -> COUNT directly with out_count, overflow and timer cleared (back-to-back windows).
REQ-024 start SHALL be ignored in COUNT and in HOLD without out_ready.
REQ-025 out_ready SHALL be ignored outside HOLD.
REQ-026 All outputs SHALL be driven directly from registers (no combinational path from inputs to outputs).

Reset
REQ-027 rst_n==0 SHALL immediately, without waiting for clk, force state=IDLE, prev=0, timer=0, out_count=0, overflow=0, out_valid=0, busy=0.
REQ-028 Reset asserted mid-COUNT or mid-HOLD SHALL discard the window; after release the block SHALL wait in IDLE for start.
REQ-029 First clk edge after rst_n deasserts SHALL be treated as a normal edge (start may be accepted).

Verification
REQ-030 Reset: rst_n low with clk stopped -> out_valid=0, busy=0, out_count=0, overflow=0 immediately.
REQ-031 Toggle: WINDOW=16, in0=0 during the start cycle, then 1,0,1,0... over 16 COUNT cycles -> out_valid after 16 edges, out_count=8, overflow=0.
REQ-032 Constant: in0 held 1 from before start through window -> out_count=0; single 0->1 at the last COUNT edge -> out_count=1.
REQ-033 Backpressure: out_ready low 5 cycles in HOLD, in0 toggling -> out_valid stays 1, out_count unchanged; out_ready high one edge -> out_valid=0, IDLE.
REQ-034 Saturation: WIDTH=2, WINDOW=16, toggling in0 -> out_count=3, overflow=1; next window with in0=0 -> out_count=0, overflow=0.
REQ-035 Back-to-back and mid-reset: start+out_ready in same HOLD edge -> busy=1 next cycle, out_count=0; rst_n pulse at COUNT cycle 7 -> all outputs 0 at once, no out_valid until a new start.

Source files
------------

// File: rtl/edge_window_counter_if.sv
// Bundle of monitored input, start/result handshake and status outputs
// for edge_window_counter. The DUT takes the slave view; the driver takes
// the master view.
interface edge_window_counter_if #(
    parameter int WIDTH = 8
);
    logic             in0;
    logic             start;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_count;
    logic             overflow;
    logic             busy;

    modport master (
        output in0,
        output start,
        output out_ready,
        input  out_valid,
        input  out_count,
        input  overflow,
        input  busy
    );

    modport slave (
        input  in0,
        input  start,
        input  out_ready,
        output out_valid,
        output out_count,
        output overflow,
        output busy
    );
endinterface

// File: rtl/edge_window_counter.sv
// Counts rising edges of a sampled single-bit signal over a fixed window of
// WINDOW clock cycles, then holds the (saturating) count until the consumer
// accepts it. A start on the accepting edge chains straight into a new window.
// Every output is a register, so nothing combinational reaches the ports.
module edge_window_counter #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    edge_window_counter_if.slave  bus
);
    localparam int TW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(WINDOW - 1);
    localparam logic [WIDTH-1:0] COUNT_MAX  = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prev_q;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             rise_s;

    // Rising edge relative to the previous cycle's sample, in any state.
    assign rise_s = bus.in0 & ~prev_q;

    // Next-state and next-output logic for the IDLE/COUNT/HOLD controller.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_COUNT;
                    timer_d = {TW{1'b0}};
                    count_d = {WIDTH{1'b0}};
                    ovf_d   = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            S_COUNT: begin
                // Saturate instead of wrapping; the sticky flag records the lost edge.
                if (rise_s) begin
                    if (count_q == COUNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    count_d = count_q;
                end
                if (timer_q == TIMER_LAST) begin
                    state_d = S_HOLD;
                    timer_d = {TW{1'b0}};
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    if (bus.start) begin
                        state_d = S_COUNT;
                        timer_d = {TW{1'b0}};
                        count_d = {WIDTH{1'b0}};
                        ovf_d   = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = {TW{1'b0}};
                count_d = {WIDTH{1'b0}};
                ovf_d   = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, sample and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            prev_q  <= 1'b0;
            timer_q <= {TW{1'b0}};
            count_q <= {WIDTH{1'b0}};
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= bus.in0;
            timer_q <= timer_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_count = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_edge_window_counter.sv
// Directed bench for edge_window_counter: one 8-bit instance and one 2-bit
// instance (saturation), both with a 16-cycle window, sharing clock and reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_edge_window_counter;
    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    edge_window_counter_if #(.WIDTH(8)) if_a ();
    edge_window_counter_if #(.WIDTH(2)) if_b ();

    edge_window_counter #(.WIDTH(8), .WINDOW(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    edge_window_counter #(.WIDTH(2), .WINDOW(16)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    // Free-running clock once enabled; held low while clk_en is 0.
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        if_a.in0 = 1'b0; if_a.start = 1'b0; if_a.out_ready = 1'b0;
        if_b.in0 = 1'b0; if_b.start = 1'b0; if_b.out_ready = 1'b0;

        // Reset with the clock stopped: outputs must clear immediately.
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(if_a.out_valid), 32'd0);
        check("rst_busy",  32'(if_a.busy),      32'd0);
        check("rst_count", 32'(if_a.out_count), 32'd0);
        check("rst_ovf",   32'(if_a.overflow),  32'd0);
        check("rst_b_count", 32'(if_b.out_count), 32'd0);
        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // Toggle window: in0 0 at start, then 1,0,1,0... -> 8 edges.
        if_a.in0 = 1'b0; if_a.start = 1'b1;
        tick();
        check("tog_busy0",  32'(if_a.busy),      32'd1);
        check("tog_count0", 32'(if_a.out_count), 32'd0);
        for (int k = 0; k < 15; k++) begin
            if_a.in0 = (k % 2 == 0);   // start kept high: must be ignored in COUNT
            tick();
        end
        check("tog_lat_valid", 32'(if_a.out_valid), 32'd0);
        check("tog_lat_busy",  32'(if_a.busy),      32'd1);
        if_a.in0 = 1'b0;
        tick();
        check("tog_valid", 32'(if_a.out_valid), 32'd1);
        check("tog_count", 32'(if_a.out_count), 32'd8);
        check("tog_ovf",   32'(if_a.overflow),  32'd0);
        check("tog_busy",  32'(if_a.busy),      32'd0);

        // Backpressure: ready low, in0 toggling, start high -> all ignored.
        for (int k = 0; k < 5; k++) begin
            if_a.in0 = (k % 2 == 0);
            tick();
        end
        check("bp_valid", 32'(if_a.out_valid), 32'd1);
        check("bp_count", 32'(if_a.out_count), 32'd8);
        check("bp_busy",  32'(if_a.busy),      32'd0);
        if_a.start = 1'b0; if_a.out_ready = 1'b1;
        tick();
        if_a.out_ready = 1'b0;
        check("bp_acc_valid", 32'(if_a.out_valid), 32'd0);
        check("bp_acc_busy",  32'(if_a.busy),      32'd0);
        tick();
        check("bp_idle_valid", 32'(if_a.out_valid), 32'd0);

        // Constant high through the whole window -> no edges.
        if_a.in0 = 1'b1;
        tick();
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        check("const_valid", 32'(if_a.out_valid), 32'd1);
        check("const_count", 32'(if_a.out_count), 32'd0);
        if_a.out_ready = 1'b1;
        tick();
        if_a.out_ready = 1'b0;

        // Single 0->1 on the last COUNT edge is counted.
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        if_a.in0 = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        check("last_valid_early", 32'(if_a.out_valid), 32'd0);
        if_a.in0 = 1'b1;
        tick();
        check("last_valid", 32'(if_a.out_valid), 32'd1);
        check("last_count", 32'(if_a.out_count), 32'd1);

        // Back-to-back: ready and start on the same HOLD edge.
        if_a.out_ready = 1'b1; if_a.start = 1'b1; if_a.in0 = 1'b0;
        tick();
        if_a.out_ready = 1'b0; if_a.start = 1'b0;
        check("b2b_busy",  32'(if_a.busy),      32'd1);
        check("b2b_count", 32'(if_a.out_count), 32'd0);
        check("b2b_valid", 32'(if_a.out_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            if_a.in0 = (k % 2 == 0);
            tick();
        end
        check("mid_count", 32'(if_a.out_count), 32'd3);
        check("mid_busy",  32'(if_a.busy),      32'd1);

        // Reset pulse mid-window, between clock edges.
        #1 rst_n = 1'b0;
        #1;
        check("mrst_busy",  32'(if_a.busy),      32'd0);
        check("mrst_count", 32'(if_a.out_count), 32'd0);
        check("mrst_valid", 32'(if_a.out_valid), 32'd0);
        check("mrst_ovf",   32'(if_a.overflow),  32'd0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if_a.in0 = (k % 2 == 0);
            tick();
        end
        check("mrst_after_valid", 32'(if_a.out_valid), 32'd0);
        check("mrst_after_busy",  32'(if_a.busy),      32'd0);

        // Saturation on the 2-bit instance: 8 edges -> 3 with overflow.
        if_b.in0 = 1'b0; if_b.start = 1'b1;
        tick();
        if_b.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if_b.in0 = (k % 2 == 0);
            tick();
        end
        check("sat_valid", 32'(if_b.out_valid), 32'd1);
        check("sat_count", 32'(if_b.out_count), 32'd3);
        check("sat_ovf",   32'(if_b.overflow),  32'd1);
        tick();
        tick();
        check("sat_ovf_sticky", 32'(if_b.overflow), 32'd1);
        if_b.in0 = 1'b0; if_b.out_ready = 1'b1; if_b.start = 1'b1;
        tick();
        if_b.out_ready = 1'b0; if_b.start = 1'b0;
        check("sat2_ovf_clr", 32'(if_b.overflow),  32'd0);
        check("sat2_busy",    32'(if_b.busy),      32'd1);
        for (int k = 0; k < 16; k++) tick();
        check("sat2_valid", 32'(if_b.out_valid), 32'd1);
        check("sat2_count", 32'(if_b.out_count), 32'd0);
        check("sat2_ovf",   32'(if_b.overflow),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
